// File: rtl/board_pkg.sv
// Shared constants, FSM state type and row-slice helper for the line-clear block.
package board_pkg;

    localparam int BOARD_ROWS = 20;
    localparam int BOARD_COLS = 10;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        METRIC,
        DONE
    } lineclear_state_t;

    // Row r of a packed board; row 0 is the top of the well.
    function automatic logic [BOARD_COLS-1:0] row_of(
        input logic [BOARD_ROWS*BOARD_COLS-1:0] board,
        input int                               r
    );
        return board[r*BOARD_COLS +: BOARD_COLS];
    endfunction

endpackage

// File: rtl/board_metrics.sv
// Column-height and hole accumulator fed one board row per cycle, top row first.
// Only instantiated when LINECLEAR_METRICS_EN is defined.
module board_metrics #(
    parameter int ROWS = 20,
    parameter int COLS = 10,
    parameter int IW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            row_en,
    input  logic [IW-1:0]   row_idx,
    input  logic [COLS-1:0] row_data,
    output logic [7:0]      holes,
    output logic [7:0]      agg_height
);

    logic [COLS-1:0] seen;
    logic [COLS-1:0] seen_next;
    logic [7:0]      holes_next;
    logic [7:0]      agg_next;

    // The first filled cell of a column fixes its height; empty cells under it are holes.
    always_comb begin
        seen_next  = seen;
        holes_next = holes;
        agg_next   = agg_height;
        for (int c = 0; c < COLS; c++) begin
            if (row_data[c]) begin
                if (!seen_next[c]) begin
                    agg_next = agg_next + (8'(ROWS) - 8'(row_idx));
                end
                seen_next[c] = 1'b1;
            end else if (seen_next[c]) begin
                holes_next = holes_next + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen       <= '0;
            holes      <= '0;
            agg_height <= '0;
        end else if (start) begin
            seen       <= '0;
            holes      <= '0;
            agg_height <= '0;
        end else if (row_en) begin
            seen       <= seen_next;
            holes      <= holes_next;
            agg_height <= agg_next;
        end
    end

endmodule

// File: rtl/board_lineclear.sv
// Removes full rows from a merged board and compacts the rest toward the bottom, one row per cycle.
// Optional METRIC pass (holes, aggregate height) is enabled by defining LINECLEAR_METRICS_EN.
module board_lineclear
    import board_pkg::*;
#(
    parameter int ROWS  = BOARD_ROWS,
    parameter int COLS  = BOARD_COLS,
    parameter int CNT_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear_request,
    input  logic                 board_valid,
    input  logic [ROWS*COLS-1:0] board_in,
    output logic                 busy,
    output logic                 clear_done,
    output logic                 out_valid,
    output logic [ROWS*COLS-1:0] board_out,
    output logic [CNT_W-1:0]     lines_cleared,
    output logic [7:0]           holes,
    output logic [7:0]           agg_height
);

    localparam int            IW   = $clog2(ROWS);
    localparam logic [IW-1:0] LAST = IW'(ROWS - 1);

    lineclear_state_t    state;
    logic [ROWS*COLS-1:0] src;
    logic [IW-1:0]       rd;
    logic [IW-1:0]       wr;
    logic [COLS-1:0]     cur_row;

    assign cur_row = row_of(src, int'(rd));

`ifdef LINECLEAR_METRICS_EN
    logic [IW-1:0] mr;
`endif

    // Rows above the final write pointer keep the zeros written at accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            src           <= '0;
            board_out     <= '0;
            rd            <= '0;
            wr            <= '0;
            lines_cleared <= '0;
            busy          <= 1'b0;
            clear_done    <= 1'b0;
            out_valid     <= 1'b0;
`ifdef LINECLEAR_METRICS_EN
            mr            <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    clear_done <= 1'b0;
                    if (clear_request) begin
                        src           <= board_in;
                        out_valid     <= board_valid;
                        board_out     <= '0;
                        rd            <= LAST;
                        wr            <= LAST;
                        lines_cleared <= '0;
                        busy          <= 1'b1;
                        state         <= SCAN;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                SCAN: begin
                    if (&cur_row) begin
                        lines_cleared <= lines_cleared + 1'b1;
                    end else begin
                        board_out[int'(wr)*COLS +: COLS] <= cur_row;
                        if (wr != '0) begin
                            wr <= wr - 1'b1;
                        end
                    end
                    if (rd == '0) begin
`ifdef LINECLEAR_METRICS_EN
                        mr    <= '0;
                        state <= METRIC;
`else
                        state <= DONE;
`endif
                    end else begin
                        rd <= rd - 1'b1;
                    end
                end
                METRIC: begin
`ifdef LINECLEAR_METRICS_EN
                    mr <= mr + 1'b1;
                    if (mr == LAST) begin
                        state <= DONE;
                    end
`else
                    state <= DONE;
`endif
                end
                DONE: begin
                    clear_done <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LINECLEAR_METRICS_EN
    board_metrics #(
        .ROWS (ROWS),
        .COLS (COLS),
        .IW   (IW)
    ) u_metrics (
        .clk        (clk),
        .rst        (rst),
        .start      (state == IDLE && clear_request),
        .row_en     (state == METRIC),
        .row_idx    (mr),
        .row_data   (row_of(board_out, int'(mr))),
        .holes      (holes),
        .agg_height (agg_height)
    );
`else
    assign holes      = 8'd0;
    assign agg_height = 8'd0;
`endif

endmodule

// File: tb/tb_board_lineclear.sv
// Scoreboard bench for board_lineclear: expected results queued at request, checked at clear_done.
module tb_board_lineclear;

    localparam int ROWS = 20;
    localparam int COLS = 10;
    localparam int N    = ROWS * COLS;
`ifdef LINECLEAR_METRICS_EN
    localparam int LAT = 2 * ROWS + 1;
`else
    localparam int LAT = ROWS + 1;
`endif

    typedef struct {
        logic [N-1:0] board;
        logic [4:0]   lines;
        logic         valid;
        logic [7:0]   holes;
        logic [7:0]   agg;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clear_request = 1'b0;
    logic         board_valid = 1'b0;
    logic [N-1:0] board_in = '0;
    logic         busy;
    logic         clear_done;
    logic         out_valid;
    logic [N-1:0] board_out;
    logic [4:0]   lines_cleared;
    logic [7:0]   holes;
    logic [7:0]   agg_height;

    int   tests_run = 0;
    int   tests_failed = 0;
    int   cyc = 0;
    int   accept_cyc = 0;
    int   done_count = 0;
    exp_t sb[$];
    exp_t mon_e;

    board_lineclear dut (
        .clk           (clk),
        .rst           (rst),
        .clear_request (clear_request),
        .board_valid   (board_valid),
        .board_in      (board_in),
        .busy          (busy),
        .clear_done    (clear_done),
        .out_valid     (out_valid),
        .board_out     (board_out),
        .lines_cleared (lines_cleared),
        .holes         (holes),
        .agg_height    (agg_height)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [255:0] act, input logic [255:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference: each surviving row drops by the number of full rows beneath it.
    function automatic exp_t model(input logic [N-1:0] b, input logic v);
        exp_t e;
        int   shift;
        int   top;
        logic [COLS-1:0] row;
        e.board = '0;
        e.lines = '0;
        e.valid = v;
        e.holes = '0;
        e.agg   = '0;
        for (int r = 0; r < ROWS; r++) begin
            row = b[r*COLS +: COLS];
            if (row == {COLS{1'b1}}) begin
                e.lines = e.lines + 5'd1;
            end else begin
                shift = 0;
                for (int k = r + 1; k < ROWS; k++)
                    if (b[k*COLS +: COLS] == {COLS{1'b1}}) shift++;
                e.board[(r+shift)*COLS +: COLS] = row;
            end
        end
`ifdef LINECLEAR_METRICS_EN
        for (int c = 0; c < COLS; c++) begin
            top = -1;
            for (int r = 0; r < ROWS; r++) begin
                if (e.board[r*COLS + c]) begin
                    if (top < 0) top = r;
                end else if (top >= 0) begin
                    e.holes = e.holes + 8'd1;
                end
            end
            if (top >= 0) e.agg = e.agg + 8'(ROWS - top);
        end
`else
        top = 0;
        shift = top;
`endif
        return e;
    endfunction

    task automatic applyStimulus(input logic [N-1:0] b, input logic v);
        @(negedge clk);
        board_in      = b;
        board_valid   = v;
        clear_request = 1'b1;
        sb.push_back(model(b, v));
        @(posedge clk);
        #1;
        accept_cyc    = cyc;
        clear_request = 1'b0;
        checkOutput("busy_after_accept", busy, 1'b1);
    endtask

    task automatic waitDone(input int target);
        bit hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            #1;
            if (done_count >= target) hit = 1;
        end
        if (!hit) checkOutput("done_timeout", 1'b0, 1'b1);
        @(negedge clk);
        #1;
        checkOutput("busy_drops", busy, 1'b0);
    endtask

    always @(negedge clk) begin
        if (!rst && clear_done) begin
            done_count++;
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", 1'b1, 1'b0);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("latency", 256'(cyc - accept_cyc), 256'(LAT));
                checkOutput("board_out", board_out, mon_e.board);
                checkOutput("lines_cleared", lines_cleared, mon_e.lines);
                checkOutput("out_valid", out_valid, mon_e.valid);
                checkOutput("holes", holes, mon_e.holes);
                checkOutput("agg_height", agg_height, mon_e.agg);
                checkOutput("busy_at_done", busy, 1'b1);
            end
        end
    end

    task automatic checkCleared(input string tag);
        checkOutput({tag, "_busy"}, busy, 1'b0);
        checkOutput({tag, "_done"}, clear_done, 1'b0);
        checkOutput({tag, "_valid"}, out_valid, 1'b0);
        checkOutput({tag, "_board"}, board_out, '0);
        checkOutput({tag, "_lines"}, lines_cleared, '0);
        checkOutput({tag, "_holes"}, holes, '0);
        checkOutput({tag, "_agg"}, agg_height, '0);
    endtask

    initial begin
        logic [N-1:0] b;
        int jobs = 0;

        #12;
        checkCleared("reset");
        @(negedge clk);
        rst = 1'b0;

        // Empty board
        applyStimulus('0, 1'b1);
        waitDone(++jobs);

        // Single clear at the bottom
        b = '0;
        b[19*COLS +: COLS] = 10'h3FF;
        b[18*COLS +: COLS] = 10'h001;
        applyStimulus(b, 1'b1);
        waitDone(++jobs);

        // Tetris
        b = '0;
        for (int r = 16; r < 20; r++) b[r*COLS +: COLS] = 10'h3FF;
        b[15*COLS +: COLS] = 10'h2AA;
        applyStimulus(b, 1'b1);
        waitDone(++jobs);

        // Interleaved full and partial rows
        b = '0;
        b[19*COLS +: COLS] = 10'h3FF;
        b[18*COLS +: COLS] = 10'h00F;
        b[17*COLS +: COLS] = 10'h3FF;
        b[16*COLS +: COLS] = 10'h00F;
        applyStimulus(b, 1'b1);
        waitDone(++jobs);

        // Random boards, some rows forced full, mixed validity
        for (int t = 0; t < 4; t++) begin
            b = '0;
            for (int r = 0; r < ROWS; r++)
                b[r*COLS +: COLS] = ($urandom_range(0, 3) == 0) ? 10'h3FF : 10'($urandom_range(0, 1023));
            applyStimulus(b, (t % 2) == 0);
            waitDone(++jobs);
        end

        // Reset in the middle of SCAN discards the job
        b = '0;
        b[19*COLS +: COLS] = 10'h3FF;
        b[5*COLS +: COLS]  = 10'h155;
        applyStimulus(b, 1'b1);
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkCleared("midscan_rst");
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (LAT + 10) @(negedge clk);
        checkOutput("no_done_after_rst", 256'(done_count), 256'(jobs));
        applyStimulus(b, 1'b1);
        waitDone(++jobs);

        // Column-0 tower with holes; a request during busy must be ignored
        b = '0;
        b[10*COLS] = 1'b1;
        b[19*COLS] = 1'b1;
        applyStimulus(b, 1'b1);
        repeat (5) @(negedge clk);
        board_in      = {N{1'b1}};
        clear_request = 1'b1;
        @(negedge clk);
        clear_request = 1'b0;
        waitDone(++jobs);
        repeat (LAT + 10) @(negedge clk);
        checkOutput("ignored_request", 256'(done_count), 256'(jobs));
        checkOutput("queue_empty", 256'(sb.size()), 256'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
